// File: rtl/play_input_service_master_if.sv
// Avalon-MM link between the play-button service master and the edge-capture PIO slave.
// Handshake: a transfer is any cycle with avm_chipselect=1; avm_write_n=0 makes it a write,
// otherwise it is a read whose data is valid exactly one cycle later. There is no waitrequest.
interface play_input_service_master_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/play_input_service_master.sv
// Services the play-button edge-capture PIO: arms its irq mask, then reads, clears and
// counts captured edges on irq or poll timeout, with a holdoff window to absorb bounce.
module play_input_service_master #(
  parameter int          POLL_CYCLES    = 1024,
  parameter int          HOLDOFF_CYCLES = 50000,
  parameter int          COUNT_W        = 8,
  parameter logic [31:0] MASK_VALUE     = 32'h1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       irq_in,
  play_input_service_master_if.master avm,
  output logic                       event_pulse,
  output logic [COUNT_W-1:0]         event_count,
  output logic                       busy,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_READ    = 3'd2,
    S_WAIT    = 3'd3,
    S_CLEAR   = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  state_t            state;
  logic              init_sent;
  logic [POLL_W-1:0] poll_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              unused_rd;

  // Only the capture bit of the edge-capture register matters here.
  assign unused_rd = ^avm.avm_readdata[31:1];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_INIT;
      init_sent          <= 1'b0;
      poll_cnt           <= '0;
      hold_cnt           <= '0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_address    <= 2'd0;
      avm.avm_writedata  <= 32'h0;
      event_pulse        <= 1'b0;
      event_count        <= '0;
      busy               <= 1'b1;
    end else begin
      // Bus outputs describe the state being entered, so they default to idle each cycle.
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_address    <= 2'd0;
      avm.avm_writedata  <= 32'h0;
      event_pulse        <= 1'b0;

      case (state)
        S_INIT: begin
          if (!init_sent) begin
            init_sent          <= 1'b1;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write_n    <= 1'b0;
            avm.avm_address    <= 2'd2;
            avm.avm_writedata  <= MASK_VALUE;
          end else begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            poll_cnt <= '0;
          end
        end

        S_IDLE: begin
          if (!enable) begin
            poll_cnt <= '0;
          end else if (irq_in || (POLL_CYCLES != 0 && poll_cnt == POLL_LAST)) begin
            poll_cnt           <= '0;
            state              <= S_READ;
            busy               <= 1'b1;
            avm.avm_chipselect <= 1'b1;
            avm.avm_address    <= 2'd3;
          end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
          end
        end

        S_READ: state <= S_WAIT;

        // Read data from the READ cycle is on the bus during this cycle.
        S_WAIT: begin
          if (avm.avm_readdata[0]) begin
            state              <= S_CLEAR;
            avm.avm_chipselect <= 1'b1;
            avm.avm_write_n    <= 1'b0;
            avm.avm_address    <= 2'd3;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_CLEAR: begin
          event_pulse <= 1'b1;
          event_count <= event_count + COUNT_W'(1);
          hold_cnt    <= '0;
          if (HOLDOFF_CYCLES == 0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_HOLDOFF;
          end
        end

        S_HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            hold_cnt <= '0;
            poll_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_play_input_service_master.sv
// Bench for play_input_service_master: an irq-driven instance with a capture-register model
// and a poll-only instance that never sees an edge.
module tb_play_input_service_master;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       irq_in = 1'b0;
  logic       cap_bit = 1'b0;
  logic       event_pulse, busy;
  logic [7:0] event_count;
  logic [2:0] state_dbg;
  logic       event_pulse_p, busy_p;
  logic [7:0] event_count_p;
  logic [2:0] state_dbg_p;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulse_seen = 0;
  int poll_reads = 0;
  int poll_clears = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_count = 8'd0;

  typedef struct {
    logic       cap;
    int         exp_pulses;
    logic [7:0] exp_count;
  } vec_t;
  vec_t vecs[6];

  play_input_service_master_if bus ();
  play_input_service_master_if bus_p ();

  play_input_service_master #(
    .POLL_CYCLES(0), .HOLDOFF_CYCLES(HOLD), .COUNT_W(8), .MASK_VALUE(32'h1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .irq_in(irq_in), .avm(bus),
    .event_pulse(event_pulse), .event_count(event_count), .busy(busy), .state_dbg(state_dbg)
  );

  play_input_service_master #(
    .POLL_CYCLES(8), .HOLDOFF_CYCLES(HOLD), .COUNT_W(8), .MASK_VALUE(32'h1)
  ) dut_poll (
    .clk(clk), .reset_n(reset_n), .enable(1'b1), .irq_in(1'b0), .avm(bus_p),
    .event_pulse(event_pulse_p), .event_count(event_count_p), .busy(busy_p),
    .state_dbg(state_dbg_p)
  );

  assign bus_p.avm_readdata = 32'h0;

  // clock / reset-independent infrastructure
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Edge-capture register read port: read latency of one cycle.
  always @(posedge clk)
    bus.avm_readdata <= (bus.avm_chipselect && bus.avm_write_n && bus.avm_address == 2'd3)
                        ? {31'b0, cap_bit} : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: each serviced edge must pulse once with the predicted count
  initial forever begin
    @(negedge clk);
    if (reset_n && event_pulse) begin
      pulse_seen++;
      if (exp_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
      else check("pulse_count", 32'(event_count), 32'(exp_q.pop_front()));
    end
  end

  // poll-only instance: a read every 10 cycles, never a clear
  initial begin
    int last_cyc;
    logic last_ok;
    last_cyc = 0;
    last_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        last_ok = 1'b0;
      end else if (bus_p.avm_chipselect && bus_p.avm_write_n) begin
        poll_reads++;
        check("poll_addr", 32'(bus_p.avm_address), 32'd3);
        if (last_ok) check("poll_interval", 32'(cyc - last_cyc), 32'd10);
        last_cyc = cyc;
        last_ok = 1'b1;
      end else if (bus_p.avm_chipselect && !bus_p.avm_write_n && bus_p.avm_address == 2'd3) begin
        poll_clears++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic expect_push();
    model_count = model_count + 8'd1;
    exp_q.push_back(model_count);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cs"}, 32'(bus.avm_chipselect), 32'd0);
    check({tag, "_wn"}, 32'(bus.avm_write_n), 32'd1);
    check({tag, "_addr"}, 32'(bus.avm_address), 32'd0);
    check({tag, "_wd"}, bus.avm_writedata, 32'd0);
    check({tag, "_pulse"}, 32'(event_pulse), 32'd0);
    check({tag, "_count"}, 32'(event_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic check_init_write(input string tag);
    check({tag, "_cs"}, 32'(bus.avm_chipselect), 32'd1);
    check({tag, "_wn"}, 32'(bus.avm_write_n), 32'd0);
    check({tag, "_addr"}, 32'(bus.avm_address), 32'd2);
    check({tag, "_wd"}, bus.avm_writedata, 32'h1);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_cs"}, 32'(bus.avm_chipselect), 32'd0);
  endtask

  // driver: one irq pulse from IDLE, stepping through the whole service sequence
  task automatic run_vec(input logic cap);
    int n;
    cap_bit = cap;
    if (cap) expect_push();
    irq_in = 1'b1;
    @(negedge clk);
    irq_in = 1'b0;
    check("vec_read", {29'b0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address == 2'd3},
          32'b111);
    @(negedge clk);
    check("vec_wait_cs", 32'(bus.avm_chipselect), 32'd0);
    @(negedge clk);
    if (cap) begin
      check("vec_clear", {29'b0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address == 2'd3},
            32'b101);
      check("vec_clear_wd", bus.avm_writedata, 32'd0);
      @(negedge clk);
      check("vec_pulse", 32'(event_pulse), 32'd1);
      n = 0;
      while (busy && n < 40) begin
        n++;
        @(negedge clk);
        if (n == 1) check("vec_pulse_width", 32'(event_pulse), 32'd0);
      end
      check("vec_holdoff_len", 32'(n), 32'(HOLD));
    end else begin
      check("vec_spurious_idle", {30'b0, busy, bus.avm_chipselect}, 32'd0);
    end
    cap_bit = 1'b0;
  endtask

  task automatic fast_event();
    int n;
    cap_bit = 1'b1;
    expect_push();
    irq_in = 1'b1;
    @(negedge clk);
    irq_in = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("fast_event_done", 32'(busy), 32'd0);
    cap_bit = 1'b0;
  endtask

  initial begin
    int quiet, reads, p0, n;
    vecs[0] = '{cap: 1'b1, exp_pulses: 1, exp_count: 8'd1};
    vecs[1] = '{cap: 1'b0, exp_pulses: 0, exp_count: 8'd1};
    vecs[2] = '{cap: 1'b1, exp_pulses: 1, exp_count: 8'd2};
    vecs[3] = '{cap: 1'b1, exp_pulses: 1, exp_count: 8'd3};
    vecs[4] = '{cap: 1'b0, exp_pulses: 0, exp_count: 8'd3};
    vecs[5] = '{cap: 1'b1, exp_pulses: 1, exp_count: 8'd4};

    // reset and init write, then a silent bus with no irq
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset_n = 1'b1;
    @(negedge clk);
    check_init_write("init");
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.avm_chipselect) quiet++;
    end
    check("idle_quiet", 32'(quiet), 32'd0);

    // table of irq services with and without a captured edge
    foreach (vecs[i]) begin
      p0 = pulse_seen;
      run_vec(vecs[i].cap);
      check("vec_count", 32'(event_count), 32'(vecs[i].exp_count));
      check("vec_pulses", 32'(pulse_seen - p0), 32'(vecs[i].exp_pulses));
    end

    // enable dropped during holdoff with irq held high
    cap_bit = 1'b1;
    expect_push();
    irq_in = 1'b1;
    repeat (4) @(negedge clk);
    check("en_pulse", 32'(event_pulse), 32'd1);
    enable = 1'b0;
    cap_bit = 1'b0;
    reads = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.avm_chipselect) reads++;
    end
    check("en_no_read", 32'(reads), 32'd0);
    check("en_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("en_first_read", {29'b0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address == 2'd3},
          32'b111);
    repeat (3) @(negedge clk);
    check("level_irq_reread", {29'b0, bus.avm_chipselect, bus.avm_write_n,
          bus.avm_address == 2'd3}, 32'b111);
    irq_in = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("en_settle", 32'(busy), 32'd0);
    check("en_count", 32'(event_count), 32'd5);

    // 256 events: the 8-bit count wraps back to where it started
    p0 = pulse_seen;
    repeat (256) fast_event();
    check("wrap_pulses", 32'(pulse_seen - p0), 32'd256);
    check("wrap_count", 32'(event_count), 32'd5);

    // reset asserted during the clear write
    cap_bit = 1'b1;
    irq_in = 1'b1;
    @(negedge clk);
    irq_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_clear", {29'b0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address == 2'd3},
          32'b101);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_count = 8'd0;
    cap_bit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_init_write("reinit");
    repeat (5) @(negedge clk);
    check("reinit_count", 32'(event_count), 32'd0);

    // final scoreboard and poll-instance totals
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("poll_reads_seen", 32'(poll_reads > 100), 32'd1);
    check("poll_no_clear", 32'(poll_clears), 32'd0);
    check("poll_count", 32'(event_count_p), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
